keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles per column dwell (one "tick").
REQ-002 The module SHALL have parameter DEB_SAMPLES, default 4, giving the number of consecutive identical tick samples that count as stable (legal range 2..15).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: an asynchronous, active-low reset.
REQ-005 The module SHALL have port row, input, 4 bits: keypad rows, active-low, externally pulled up.
REQ-006 The module SHALL have port col, output, 4 bits: keypad column drive, one-hot active-low, registered.
REQ-007 The module SHALL have port press_valid, output, 1 bit: a one-cycle pulse per accepted key press.
REQ-008 The module SHALL have port scan_code, output, 4 bits: the code of the last accepted key, held between presses.

Function
REQ-009 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; a tick is the cycle in which the count equals SCAN_DIV-1.
REQ-010 The row sample SHALL be taken only on a tick, from row synchronised through a 2-flop synchroniser.
REQ-011 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-012 In SCAN, on a tick with sample == 4'hF, col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, so col_idx goes 0 -> 1 -> 2 -> 3 -> 0.
REQ-013 In SCAN, on a tick with sample != 4'hF, the FSM SHALL capture the sample, clear the match counter to 1, hold col, and enter DEBOUNCE.
REQ-014 In DEBOUNCE, on each tick where the sample equals the captured sample, the match counter SHALL increment.
REQ-015 When the match counter reaches DEB_SAMPLES, the FSM SHALL enter PRESSED.
REQ-016 In DEBOUNCE, on a tick where the sample differs from the captured sample, the FSM SHALL return to SCAN with col unchanged and no pulse.
REQ-017 The row index SHALL be the lowest-numbered low bit of the captured sample (bit 0 has highest priority when several rows are low).
REQ-018 scan_code SHALL equal {row_idx[1:0], col_idx[1:0]}, giving codes 0..15.
REQ-019 PRESSED SHALL last exactly one cycle: press_valid = 1 and scan_code updated in the same cycle, then go to RELEASE.
REQ-020 Latency SHALL be exactly one clock from the DEB_SAMPLES-th matching tick to press_valid high.
REQ-021 In RELEASE, col SHALL be held and the release counter SHALL count consecutive ticks with sample == 4'hF.
REQ-022 A non-F sample SHALL clear the release counter.
REQ-023 When the release counter reaches DEB_SAMPLES, the FSM SHALL return to SCAN, advance col one position, and generate no pulse on release.
REQ-024 A held key SHALL produce exactly one press_valid; no auto-repeat is permitted.
REQ-025 press_valid SHALL never be high for two consecutive cycles.
REQ-026 Between pulses, scan_code SHALL hold its value; press_valid SHALL be the only strobe for downstream consumers.
REQ-027 The dwell counter SHALL run freely in all states, with no restart on a state change.

Reset
REQ-028 When rst = 0, the module SHALL immediately set state = SCAN, col = 4'b1110, press_valid = 0, scan_code = 4'h0, and clear the dwell, match and release counters and the synchroniser (to 4'hF).
REQ-029 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL abort the press with no pulse; after release, scanning SHALL resume from col = 4'b1110.
REQ-030 The first tick after reset deassertion SHALL occur SCAN_DIV cycles after the first active clock edge.

Verification (SCAN_DIV = 4, DEB_SAMPLES = 3, keypad model drives row from col)
REQ-031 Idle, all rows high for 64 cycles -> col visits 1110, 1101, 1011, 0111 every 4 cycles, press_valid stays 0.
REQ-032 Key row 2 / col 1 held 40 cycles -> exactly one press_valid, scan_code = 4'h9, col held at 1101 until release is debounced.
REQ-033 Key pressed for only 2 ticks then released -> no press_valid, scan mode resumes.
REQ-034 Rows 1 and 3 pressed simultaneously on col 0 -> scan_code = 4'h4, one pulse.
REQ-035 Reset pulsed low during DEBOUNCE -> outputs at reset values immediately, no pulse; fresh press afterwards accepted normally.
REQ-036 Key released then pressed again (key 4'hF: row 3, col 3) -> second distinct press_valid with scan_code = 4'hF, and downstream shift buffer receives two codes.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with tick-based debounce.
//
// Drives one column low at a time, samples the (pulled-up, active-low) rows once per
// dwell tick, debounces both press and release, and reports each accepted key exactly
// once.
//
// Parameters
//   SCAN_DIV    clock cycles per column dwell; one tick per dwell period
//   DEB_SAMPLES consecutive identical tick samples that count as stable (2..15)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   row[3:0]    keypad rows, active-low, asynchronous to clk
//   col[3:0]    one-hot active-low column drive, registered
//   press_valid one-cycle strobe per accepted key press
//   scan_code   {row_idx, col_idx} of the last accepted key, held between presses

module keypad_scan #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEB_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       press_valid,
    output logic [3:0] scan_code
);

    localparam int unsigned   DivW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivMax  = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]    DebTarget = 4'(DEB_SAMPLES);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q;
    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      col_q, col_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [3:0]      cap_q, cap_d;
    logic [3:0]      match_q, match_d;
    logic [3:0]      rel_q, rel_d;
    logic            press_q, press_d;
    logic [3:0]      code_q, code_d;
    logic            tick;
    logic [3:0]      sample;
    logic [1:0]      row_idx;

    // Dwell counter runs freely regardless of FSM state.
    assign tick   = (div_q == DivMax);
    assign sample = sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Rows are asynchronous to clk; resets to "no key" so no false capture after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= row;
            sync2_q <= sync1_q;
        end
    end

    // Lowest-numbered low row wins when several rows are low.
    always_comb begin
        row_idx = 2'd0;
        if (!cap_q[0]) begin
            row_idx = 2'd0;
        end else if (!cap_q[1]) begin
            row_idx = 2'd1;
        end else if (!cap_q[2]) begin
            row_idx = 2'd2;
        end else if (!cap_q[3]) begin
            row_idx = 2'd3;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        col_idx_d = col_idx_q;
        cap_d     = cap_q;
        match_d   = match_q;
        rel_d     = rel_q;
        press_d   = 1'b0;
        code_d    = code_q;

        unique case (state_q)
            StScan: begin
                if (tick) begin
                    if (sample == 4'hF) begin
                        col_d     = {col_q[2:0], col_q[3]};
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        cap_d   = sample;
                        match_d = 4'd1;
                        state_d = StDebounce;
                    end
                end
            end
            StDebounce: begin
                if (tick) begin
                    if (sample == cap_q) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == DebTarget) begin
                            state_d = StPressed;
                            press_d = 1'b1;
                            code_d  = {row_idx, col_idx_q};
                        end
                    end else begin
                        // Bounce or glitch: drop the candidate, keep the column.
                        state_d = StScan;
                    end
                end
            end
            StPressed: begin
                state_d = StRelease;
                rel_d   = 4'd0;
            end
            StRelease: begin
                if (tick) begin
                    if (sample == 4'hF) begin
                        rel_d = rel_q + 4'd1;
                        if (rel_q + 4'd1 == DebTarget) begin
                            state_d   = StScan;
                            col_d     = {col_q[2:0], col_q[3]};
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        rel_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d = StScan;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StScan;
            col_q     <= 4'b1110;
            col_idx_q <= 2'd0;
            cap_q     <= 4'hF;
            match_q   <= 4'd0;
            rel_q     <= 4'd0;
            press_q   <= 1'b0;
            code_q    <= 4'h0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            col_idx_q <= col_idx_d;
            cap_q     <= cap_d;
            match_q   <= match_d;
            rel_q     <= rel_d;
            press_q   <= press_d;
            code_q    <= code_d;
        end
    end

    assign col         = col_q;
    assign press_valid = press_q;
    assign scan_code   = code_q;

endmodule
